// File: rtl/token_sat_add.sv
// token_sat_add: unsigned add clamped to MAX, summed one bit wider so the carry is never lost.
module token_sat_add #(
  parameter int W   = 8,
  parameter int MAX = 128
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  logic [W:0] sum;
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    sum_o = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
  end
endmodule

// File: rtl/token_bucket.sv
// token_bucket: rate shaper granting same-cycle requests while the post-add bucket holds TOKEN_COST tokens.
module token_bucket #(
  parameter int DEN        = 16,
  parameter int RATE_NUM   = 3,
  parameter int BURST_MAX  = 8,
  parameter int TOKEN_COST = DEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic grant_o,
  output logic ready_o
);
  localparam int TOK_MAX = BURST_MAX * DEN;
  localparam int W       = $clog2(TOK_MAX + RATE_NUM + 1);
  if (RATE_NUM < 1) begin : g_bad_rate
    $fatal(1, "token_bucket: RATE_NUM must be >= 1");
  end
  if (TOKEN_COST < 1 || TOKEN_COST > TOK_MAX) begin : g_bad_cost
    $fatal(1, "token_bucket: TOKEN_COST must be in 1..BURST_MAX*DEN");
  end
  logic [W-1:0] tokens_q, tokens_d, avail;
  token_sat_add #(.W(W), .MAX(TOK_MAX)) u_add (
    .a_i  (tokens_q),
    .b_i  (W'(RATE_NUM)),
    .sum_o(avail)
  );
  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    ready_o  = rst_n && (avail >= W'(TOKEN_COST));
    grant_o  = req_i && ready_o;
    tokens_d = avail - (grant_o ? W'(TOKEN_COST) : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tokens_q <= W'(TOK_MAX);
    else        tokens_q <= tokens_d;
  end
endmodule

// File: tb/tb_token_bucket.sv
// tb_token_bucket: random and directed traffic checked against an arithmetic bucket model via a scoreboard queue.
module tb_token_bucket;
  localparam int DEN = 16, RATE = 3, BURST = 8, COST = 16, TMAX = BURST * DEN;
  logic clk = 1'b0, rst_n = 1'b0, req_i = 1'b0;
  logic grant_o, ready_o;
  token_bucket #(.DEN(DEN), .RATE_NUM(RATE), .BURST_MAX(BURST), .TOKEN_COST(COST)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .grant_o(grant_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic r; logic g; logic rdy;} exp_t;
  exp_t q[$];
  exp_t cur;
  int total = 0, bad = 0, model_tok = TMAX, mg = 0, dg = 0, d0 = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask
  task automatic cycle(input logic r);
    int avail;
    exp_t e;
    @(posedge clk);
    #1 req_i = r;
    avail = (model_tok + RATE > TMAX) ? TMAX : model_tok + RATE;
    e.r   = r;
    e.rdy = (avail >= COST);
    e.g   = r && e.rdy;
    model_tok = e.g ? avail - COST : avail;
    if (e.g) mg++;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      check("grant", {31'b0, grant_o}, {31'b0, cur.g});
      check("ready", {31'b0, ready_o}, {31'b0, cur.rdy});
      check("grant_without_req", {31'b0, grant_o & ~req_i}, 0);
      if (grant_o === 1'b1) dg++;
    end
  end
  initial begin
    req_i = 1'b1;
    #12;
    check("reset_grant", {31'b0, grant_o}, 0);
    check("reset_ready", {31'b0, ready_o}, 0);
    req_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) cycle(1'b0);
    repeat (40) cycle(1'b1);
    repeat (20) cycle(1'b0);
    repeat (20) cycle(1'b1);
    repeat (300) cycle($urandom_range(0, 99) < 30);
    repeat (50) cycle(1'b1);
    repeat (50) cycle(1'b0);
    repeat (50) cycle(1'b1);
    @(negedge clk);
    #1 d0 = dg;
    repeat (200) cycle(1'b1);
    @(negedge clk);
    #1 check("steady_rate_37_38", {31'b0, (dg - d0 >= 37) && (dg - d0 <= 38)}, 1);
    repeat (3) cycle(1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 req_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", {31'b0, grant_o}, 0);
    check("async_rst_ready", {31'b0, ready_o}, 0);
    repeat (2) @(negedge clk);
    req_i = 1'b0;
    model_tok = TMAX;
    rst_n = 1'b1;
    d0 = dg;
    repeat (9) cycle(1'b1);
    @(negedge clk);
    #1 check("refill_burst9", dg - d0, 9);
    check("grant_total", dg, mg);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
